// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage: shift-add multiply and
// restoring divide, one bit per cycle, with pipeline stall and a one-cycle done pulse.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [4:0]      rd_i,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o,
   output logic            done_o,
   output logic            busy_o,
   output logic            stall_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic            neg_q, neg_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            is_div, a_signed, b_signed, neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_diff;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0] quo_s, rem_s, fix_result;

   // Operand decode for the issue cycle: magnitudes plus the sign each op needs.
   always_comb begin
      is_div   = op_i[2];
      a_signed = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
      b_signed = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
      neg_a    = a_signed & a_i[XLEN-1];
      neg_b    = b_signed & b_i[XLEN-1];
      mag_a    = neg_a ? (~a_i + 1'b1) : a_i;
      mag_b    = neg_b ? (~b_i + 1'b1) : b_i;
   end

   // hi/lo double as product {hi,lo} for multiply and {remainder, quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_ge    = div_shift >= {1'b0, mcand_q};
      div_diff  = div_shift[XLEN-1:0] - mcand_q;
      prod_s    = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
      quo_s     = neg_q ? (~lo_q + 1'b1) : lo_q;
      rem_s     = neg_q ? (~hi_q + 1'b1) : hi_q;
      case (op_q)
         3'b000:         fix_result = prod_s[XLEN-1:0];
         3'b100, 3'b101: fix_result = quo_s;
         3'b110, 3'b111: fix_result = rem_s;
         default:        fix_result = prod_s[2*XLEN-1:XLEN];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      neg_d    = neg_q;
      count_d  = count_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               op_d    = op_i;
               rd_d    = rd_i;
               count_d = '0;
               if (is_div && (b_i == '0)) begin
                  hi_d    = a_i;
                  lo_d    = '1;
                  mcand_d = '0;
                  neg_d   = 1'b0;
                  state_d = S_FIX;
               end else if (is_div && !op_i[0] && (a_i == INT_MIN) && (b_i == '1)) begin
                  hi_d    = '0;
                  lo_d    = INT_MIN;
                  mcand_d = '0;
                  neg_d   = 1'b0;
                  state_d = S_FIX;
               end else if (is_div) begin
                  hi_d    = '0;
                  lo_d    = mag_a;
                  mcand_d = mag_b;
                  neg_d   = op_i[1] ? neg_a : (neg_a ^ neg_b);
                  state_d = S_CALC;
               end else begin
                  hi_d    = '0;
                  lo_d    = mag_b;
                  mcand_d = mag_a;
                  neg_d   = neg_a ^ neg_b;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               if (op_q[2]) begin
                  hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], div_ge};
               end else begin
                  hi_d = mul_sum[XLEN:1];
                  lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
               end
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(XLEN-1)) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               result_d = fix_result;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         neg_q    <= 1'b0;
         count_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
         neg_q    <= neg_d;
         count_q  <= count_d;
         result_q <= result_d;
      end
   end

   // rd_o must only move with result_o, so it is taken from the register loaded in FIX.
   logic [4:0] rd_out_q, rd_out_d;

   always_comb begin
      rd_out_d = rd_out_q;
      if ((state_q == S_FIX) && !flush_i) begin
         rd_out_d = rd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_out_q <= '0;
      end else begin
         rd_out_q <= rd_out_d;
      end
   end

   assign result_o = result_q;
   assign rd_o     = rd_out_q;
   assign done_o   = (state_q == S_DONE);
   assign busy_o   = (state_q != S_IDLE);
   assign stall_o  = ((state_q == S_IDLE) && start_i) || (state_q == S_CALC) || (state_q == S_FIX);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: results, latency, stall window, flush and reset.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic        flush_i;
   logic [2:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [4:0]  rd_i;
   logic [31:0] result_o;
   logic [4:0]  rd_o;
   logic        done_o;
   logic        busy_o;
   logic        stall_o;

   int checks = 0;
   int errors = 0;

   ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .start_i  (start_i),
      .flush_i  (flush_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .rd_i     (rd_i),
      .result_o (result_o),
      .rd_o     (rd_o),
      .done_o   (done_o),
      .busy_o   (busy_o),
      .stall_o  (stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge with the unit idle; start_i is raised in that cycle
   // (cycle 0). Returns #1 after the edge following DONE, i.e. the next idle cycle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_lat, input bit poke);
      int lat;
      bit stall_bad;
      logic [31:0] res;
      logic [4:0]  rdv;
      lat = -1;
      stall_bad = 1'b0;
      res = '0;
      rdv = '0;
      op_i = op; a_i = a; b_i = b; rd_i = rd; start_i = 1'b1;
      #1;
      if (!stall_o) stall_bad = 1'b1;
      for (int c = 1; c <= 40 && lat < 0; c++) begin
         @(posedge clk); #1;
         start_i = poke && (c == 5 || c == 15);
         if (poke) begin
            a_i = 32'h0BAD_0000 + 32'(c);
            b_i = 32'h0000_0011;
            rd_i = 5'd31;
            op_i = 3'(c);
         end
         if (done_o) begin
            lat = c;
            res = result_o;
            rdv = rd_o;
            if (stall_o) stall_bad = 1'b1;
         end else if (!stall_o) begin
            stall_bad = 1'b1;
         end
      end
      start_i = 1'b0;
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " result"}, res, exp);
      chk({tag, " rd"}, {27'd0, rdv}, {27'd0, rd});
      chk({tag, " stall window"}, {31'd0, stall_bad}, 32'd0);
      $display("op=%0d a=%h b=%h rd=%0d result=%h latency=%0d (%s)", op, a, b, rd, res, lat, tag);
      @(posedge clk); #1;
      chk({tag, " done one cycle"}, {31'd0, done_o}, 32'd0);
      chk({tag, " idle after done"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      bit saw_done;
      reset = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, busy_o}, 32'd0);
      chk("reset done", {31'd0, done_o}, 32'd0);
      chk("reset stall", {31'd0, stall_o}, 32'd0);
      chk("reset result", result_o, 32'd0);
      chk("reset rd", {27'd0, rd_o}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op("MUL 7*-3",       3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, 1'b0);
      run_op("MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 34, 1'b0);
      run_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 34, 1'b0);
      run_op("MULHU max*max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 34, 1'b0);
      run_op("MULHSU -1*2",    3'b010, 32'hFFFF_FFFF, 32'd2,         5'd9,  32'hFFFF_FFFF, 34, 1'b0);
      run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 34, 1'b0);
      run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 34, 1'b0);
      run_op("DIV 7/-2",       3'b100, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 34, 1'b0);
      run_op("REM 7/-2",       3'b110, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'h0000_0001, 34, 1'b0);
      run_op("DIVU by zero",   3'b101, 32'h0000_1234, 32'd0,         5'd14, 32'hFFFF_FFFF, 2,  1'b0);
      run_op("REMU by zero",   3'b111, 32'h0000_1234, 32'd0,         5'd15, 32'h0000_1234, 2,  1'b0);
      run_op("DIV overflow",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 2,  1'b0);
      run_op("REM overflow",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 2,  1'b0);
      run_op("DIVU 100/7",     3'b101, 32'd100,       32'd7,         5'd18, 32'd14,        34, 1'b0);
      run_op("REMU 100/7",     3'b111, 32'd100,       32'd7,         5'd19, 32'd2,         34, 1'b0);

      // Flush a DIV in cycle 10, then issue again in cycle 11 (done expected in cycle 45).
      saw_done = 1'b0;
      op_i = 3'b100; a_i = 32'd1000; b_i = 32'd3; rd_i = 5'd20; start_i = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         if (done_o) saw_done = 1'b1;
         if (c == 10) flush_i = 1'b1;
      end
      @(posedge clk); #1;
      flush_i = 1'b0;
      if (done_o) saw_done = 1'b1;
      chk("flush busy", {31'd0, busy_o}, 32'd0);
      chk("flush no done", {31'd0, saw_done}, 32'd0);
      chk("flush result kept", result_o, 32'd2);
      chk("flush rd kept", {27'd0, rd_o}, 32'd19);
      run_op("DIV after flush", 3'b100, 32'd1000, 32'd3, 5'd21, 32'd333, 34, 1'b0);

      // Reset in cycle 20 of a MUL.
      op_i = 3'b000; a_i = 32'd3; b_i = 32'd5; rd_i = 5'd22; start_i = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         if (c == 20) begin
            chk("busy before reset", {31'd0, busy_o}, 32'd1);
            reset = 1'b1;
         end
      end
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midop reset busy", {31'd0, busy_o}, 32'd0);
      chk("midop reset done", {31'd0, done_o}, 32'd0);
      chk("midop reset result", result_o, 32'd0);
      chk("midop reset rd", {27'd0, rd_o}, 32'd0);

      run_op("MUL ignore starts", 3'b000, 32'd123, 32'd456, 5'd23, 32'd56088, 34, 1'b1);
      run_op("MULHU back2back",   3'b011, 32'h0001_0000, 32'h0003_0000, 5'd24, 32'd3, 34, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
